// File: rtl/operand_gen_pkg.sv
// operand_gen_pkg
// Shared definitions for operand_generator and its LFSR sub-module:
//   state_t    - FSM state encoding (IDLE / RUN / DONE)
//   LFSR_TAPS  - Galois feedback mask for the 32-bit random source
//   lfsr_next  - one Galois step (right shift, XOR taps when the LSB falls out)
package operand_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'd0);
  endfunction

endpackage

// File: rtl/lfsr32.sv
// lfsr32
// 32-bit Galois LFSR used as the random operand source.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (state resets to 1)
//   load       - load seed (wins over step)
//   seed       - value loaded on load
//   step       - advance one Galois step
//   q          - current LFSR state
module lfsr32
  import operand_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  logic [31:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 32'd1;
    end else if (load) begin
      r_q <= seed;
    end else if (step) begin
      r_q <= lfsr_next(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/operand_generator.sv
// operand_generator
// Issues NUM_VECTORS operand vectors {a_out, b_out, cin_out} to a downstream
// adder under a valid/ready handshake. Default build is exhaustive: the vector
// is a (2*NBITS+1)-bit counter that wraps freely. Defining OPERAND_GEN_LFSR_EN
// adds ports mode/seed and a 32-bit Galois LFSR source (mode=1 selects it).
//
// Handshake: valid is raised by this block and stays high, with the vector
// frozen, until the consumer asserts ready in the same cycle (a transfer).
// After a transfer the next vector appears on the following cycle.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start             - begin a run (sampled in IDLE or DONE only)
//   abort             - synchronous cancel of a run (ignored outside RUN)
//   ready             - consumer accepts the presented vector
//   mode, seed        - random mode select and LFSR seed (OPERAND_GEN_LFSR_EN)
//   a_out,b_out,cin_out - operand vector
//   valid             - vector is valid
//   busy, done        - state is RUN / DONE
//   vec_count         - transfers completed in the current or last run
//   dbg_state         - current FSM state
module operand_generator
  import operand_gen_pkg::*;
#(
  parameter int          NBITS       = 8,
  parameter int unsigned NUM_VECTORS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             ready,
`ifdef OPERAND_GEN_LFSR_EN
  input  logic             mode,
  input  logic [31:0]      seed,
`endif
  output logic [NBITS-1:0] a_out,
  output logic [NBITS-1:0] b_out,
  output logic             cin_out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [31:0]      vec_count,
  output state_t           dbg_state
);

  localparam int          PW       = 2 * NBITS + 1;
  localparam logic [31:0] LAST_CNT = 32'(NUM_VECTORS - 1);

  state_t          r_state;
  logic            r_valid;
  logic [31:0]     r_cnt;
  logic [PW-1:0]   r_pat;
  logic            w_xfer;
  logic            w_start;

  assign w_xfer  = (r_state == ST_RUN) && r_valid && ready;
  assign w_start = (r_state != ST_RUN) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_cnt   <= 32'd0;
      r_pat   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_valid <= 1'b1;
            r_cnt   <= 32'd0;
            r_pat   <= '0;
          end
        end
        ST_RUN: begin
          // A transfer coinciding with abort still counts.
          if (w_xfer) begin
            r_cnt <= r_cnt + 32'd1;
          end
          if (abort) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end else if (w_xfer) begin
            r_pat <= r_pat + PW'(1);
            if (r_cnt == LAST_CNT) begin
              r_state <= ST_DONE;
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef OPERAND_GEN_LFSR_EN
  logic        r_mode;
  logic [31:0] w_lfsr;
  logic [31:0] w_seed;

  // A zero seed would lock the LFSR at zero, so it is replaced by 1.
  assign w_seed = (seed == 32'd0) ? 32'd1 : seed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= 1'b0;
    end else if (w_start) begin
      r_mode <= mode;
    end
  end

  lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_start),
    .seed  (w_seed),
    .step  (w_xfer),
    .q     (w_lfsr)
  );

  assign a_out   = r_mode ? w_lfsr[NBITS-1:0]       : r_pat[PW-1 -: NBITS];
  assign b_out   = r_mode ? w_lfsr[2*NBITS-1:NBITS] : r_pat[NBITS:1];
  assign cin_out = r_mode ? w_lfsr[31]              : r_pat[0];
`else
  assign a_out   = r_pat[PW-1 -: NBITS];
  assign b_out   = r_pat[NBITS:1];
  assign cin_out = r_pat[0];
`endif

  assign valid     = r_valid;
  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign vec_count = r_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_operand_generator.sv
`timescale 1ns/1ps
module tb_operand_generator;
  import operand_gen_pkg::*;

  localparam int NB_A = 4;
  localparam int NV_A = 3;
  localparam int NB_B = 1;
  localparam int NV_B = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] start = '0;
  logic [1:0] abort = '0;
  logic [1:0] ready = '0;
`ifdef OPERAND_GEN_LFSR_EN
  logic [1:0]  mode = '0;
  logic [31:0] seed [2];
`endif

  logic [NB_A-1:0] a_a, b_a;
  logic [NB_B-1:0] a_b, b_b;
  logic [1:0]      cin, valid, busy, done;
  logic [31:0]     cnt [2];
  state_t          st [2];
  logic [1:0][31:0] vec;

  assign vec[0] = 32'({a_a, b_a, cin[0]});
  assign vec[1] = 32'({a_b, b_b, cin[1]});

  operand_generator #(.NBITS(NB_A), .NUM_VECTORS(NV_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .ready(ready[0]),
`ifdef OPERAND_GEN_LFSR_EN
    .mode(mode[0]), .seed(seed[0]),
`endif
    .a_out(a_a), .b_out(b_a), .cin_out(cin[0]), .valid(valid[0]), .busy(busy[0]),
    .done(done[0]), .vec_count(cnt[0]), .dbg_state(st[0])
  );

  operand_generator #(.NBITS(NB_B), .NUM_VECTORS(NV_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .ready(ready[1]),
`ifdef OPERAND_GEN_LFSR_EN
    .mode(mode[1]), .seed(seed[1]),
`endif
    .a_out(a_b), .b_out(b_b), .cin_out(cin[1]), .valid(valid[1]), .busy(busy[1]),
    .done(done[1]), .vec_count(cnt[1]), .dbg_state(st[1])
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nbits_of(input int d);
    return (d == 0) ? NB_A : NB_B;
  endfunction

  function automatic int nvec_of(input int d);
    return (d == 0) ? NV_A : NV_B;
  endfunction

  // Exhaustive reference: the k-th vector {a,b,cin} is k modulo 2^(2*nb+1).
  function automatic logic [31:0] exh_vec(input int nb, input int k);
    return 32'(k % (1 << (2 * nb + 1)));
  endfunction

  // Random reference: Galois LFSR, a = low nb bits, b = next nb bits, cin = bit 31.
  function automatic logic [31:0] lfsr_model_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [31:0] lfsr_vec(input int nb, input logic [31:0] s);
    logic [31:0] m, a, b;
    m = (32'd1 << nb) - 32'd1;
    a = s & m;
    b = (s >> nb) & m;
    return (a << (nb + 1)) | (b << 1) | 32'(s[31]);
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // ---------------- monitor ----------------
  logic [1:0]       prev_stall = '0;
  logic [1:0][31:0] prev_vec;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        prev_stall[d] <= 1'b0;
      end else begin
        if (prev_stall[d])
          check($sformatf("hold_%0d", d), {valid[d], vec[d][30:0]}, {1'b1, prev_vec[d][30:0]});
        if (valid[d] && ready[d]) begin
          if (q_size(d) == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL vec_%0d: got unexpected vector 0x%0h, expected none", d, vec[d]);
          end else begin
            logic [31:0] e;
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("vec_%0d", d), vec[d], e);
          end
        end
        prev_stall[d] <= valid[d] && !ready[d] && !abort[d];
        prev_vec[d]   <= vec[d];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int d);
    int nb, nv;
    logic [31:0] v;
    nb = nbits_of(d);
    nv = nvec_of(d);
`ifdef OPERAND_GEN_LFSR_EN
    if (mode[d]) begin
      logic [31:0] s;
      s = (seed[d] == 32'd0) ? 32'd1 : seed[d];
      for (int k = 0; k < nv; k++) begin
        v = lfsr_vec(nb, s);
        if (d == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
        s = lfsr_model_step(s);
      end
    end else
`endif
    for (int k = 0; k < nv; k++) begin
      v = exh_vec(nb, k);
      if (d == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
    end
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
  endtask

  task automatic run_until_done(input int d, input bit rnd_ready);
    int cyc;
    cyc = 0;
    while (!done[d] && cyc < 500) begin
      ready[d] = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      cyc++;
    end
    ready[d] = 1'b0;
    check($sformatf("done_%0d", d), 32'(done[d]), 32'd1);
    check($sformatf("count_%0d", d), cnt[d], 32'(nvec_of(d)));
    check($sformatf("valid_off_%0d", d), 32'(valid[d]), 32'd0);
    check($sformatf("drained_%0d", d), 32'(q_size(d)), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_vec_%0d", tag, d), vec[d], 32'd0);
      check($sformatf("%s_flags_%0d", tag, d), {29'd0, valid[d], busy[d], done[d]}, 32'd0);
      check($sformatf("%s_cnt_%0d", tag, d), cnt[d], 32'd0);
      check($sformatf("%s_state_%0d", tag, d), 32'(st[d]), 32'(ST_IDLE));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
`ifdef OPERAND_GEN_LFSR_EN
    seed[0] = 32'd0;
    seed[1] = 32'd0;
`endif
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // No vector until start.
    repeat (3) tick();
    check("idle_valid_a", 32'(valid[0]), 32'd0);
    check("idle_valid_b", 32'(valid[1]), 32'd0);

    // Basic run, ready held high: vectors 0,1,2 then DONE.
    ready[0] = 1'b1;
    start_run(0);
    check("first_valid_a", 32'(valid[0]), 32'd1);
    check("first_vec_a", vec[0], 32'd0);
    check("run_busy_a", 32'(busy[0]), 32'd1);
    run_until_done(0, 1'b0);

    // Restart from DONE, stall 5 cycles on the 2nd vector; start is ignored in RUN.
    ready[0] = 1'b1;
    start_run(0);
    check("restart_cnt_a", cnt[0], 32'd0);
    check("restart_done_a", 32'(done[0]), 32'd0);
    tick();
    ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start[0] = (i == 2);
      tick();
      check("stall_valid_a", 32'(valid[0]), 32'd1);
      check("stall_vec_a", vec[0], 32'h1);
      check("stall_cnt_a", cnt[0], 32'd1);
    end
    start[0] = 1'b0;
    run_until_done(0, 1'b0);

    // Abort after two transfers, then abort outside RUN, then a fresh run.
    ready[0] = 1'b1;
    start_run(0);
    tick();
    tick();
    check("pre_abort_cnt_a", cnt[0], 32'd2);
    abort[0] = 1'b1;
    ready[0] = 1'b0;
    tick();
    check("abort_state_a", 32'(st[0]), 32'(ST_IDLE));
    check("abort_valid_a", 32'(valid[0]), 32'd0);
    check("abort_cnt_a", cnt[0], 32'd2);
    exp_q0.delete();
    tick();
    check("abort_idle_state_a", 32'(st[0]), 32'(ST_IDLE));
    check("abort_idle_cnt_a", cnt[0], 32'd2);
    abort[0] = 1'b0;
    start_run(0);
    check("post_abort_cnt_a", cnt[0], 32'd0);
    check("post_abort_vec_a", vec[0], 32'd0);
    run_until_done(0, 1'b1);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    check("abort_in_done_a", 32'(st[0]), 32'(ST_DONE));

    // NBITS=1: the 3-bit counter wraps after vector 8.
    ready[1] = 1'b1;
    start_run(1);
    run_until_done(1, 1'b0);

    // Abort coinciding with a transfer: the transfer still counts.
    ready[1] = 1'b1;
    start_run(1);
    tick();
    abort[1] = 1'b1;
    tick();
    abort[1] = 1'b0;
    ready[1] = 1'b0;
    check("abort_xfer_cnt_b", cnt[1], 32'd2);
    check("abort_xfer_valid_b", 32'(valid[1]), 32'd0);
    check("abort_xfer_state_b", 32'(st[1]), 32'(ST_IDLE));
    exp_q1.delete();

    // Random backpressure runs.
    for (int it = 0; it < 6; it++) begin
      int d;
      d = $urandom_range(0, 1);
      start_run(d);
      run_until_done(d, 1'b1);
    end

    // Reset mid-run clears everything immediately.
    ready[1] = 1'b1;
    start_run(1);
    repeat (3) tick();
    check("pre_reset_cnt_b", cnt[1], 32'd3);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrun");
    exp_q0.delete();
    exp_q1.delete();
    ready[1] = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_reset_valid_b", 32'(valid[1]), 32'd0);
    start_run(1);
    run_until_done(1, 1'b1);

`ifdef OPERAND_GEN_LFSR_EN
    // Random mode: seed 0 loads 1, so the first vector is a=1, b=0, cin=0.
    mode[0] = 1'b1;
    seed[0] = 32'd0;
    start_run(0);
    check("lfsr_first_vec_a", vec[0], 32'h20);
    run_until_done(0, 1'b1);
    seed[0] = $urandom;
    start_run(0);
    run_until_done(0, 1'b1);
    mode[0] = 1'b0;
`endif

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/operand_generator.md
OPERAND_GENERATOR -- requirements
Module: operand_generator

Interface
REQ-001 SHALL have parameter NBITS, default 8: operand width driven into the downstream adder; legal range 1..15.
REQ-002 SHALL have parameter NUM_VECTORS, default 256: vectors issued per run; legal range 1..2^32-1.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: begins a run when sampled high in IDLE or DONE.
REQ-006 SHALL have port abort, input, 1: synchronous cancel of the current run.
REQ-007 SHALL have port ready, input, 1: the consumer accepts the presented vector.
REQ-008 SHALL have port a_out, output, NBITS: operand a.
REQ-009 SHALL have port b_out, output, NBITS: operand b.
REQ-010 SHALL have port cin_out, output, 1: carry-in.
REQ-011 SHALL have port valid, output, 1: the vector on a_out, b_out and cin_out is valid.
REQ-012 SHALL have port busy, output, 1: high in state RUN.
REQ-013 SHALL have port done, output, 1: high in state DONE.
REQ-014 SHALL have port vec_count, output, 32: number of completed transfers in the current or last run.

Function
REQ-015 SHALL implement a three-state machine with states IDLE, RUN and DONE.
REQ-016 SHALL, on IDLE or DONE with start=1, enter RUN, clear vec_count and load the first vector; valid rises on the next cycle.
REQ-017 SHALL define a transfer as a cycle with valid=1 and ready=1; on each transfer, vec_count increments and the next vector is presented on the following cycle.
REQ-018 SHALL hold a_out, b_out, cin_out and valid stable while valid=1 and ready=0.
REQ-019 SHALL, on the transfer that makes vec_count equal NUM_VECTORS, enter DONE with valid=0 on the next cycle.
REQ-020 SHALL ignore start while in RUN.
REQ-021 SHALL, on abort=1 in RUN, enter IDLE next cycle with valid=0 and vec_count retained.
REQ-022 SHALL give abort priority over a simultaneous transfer: the transfer still counts, but no further vector is presented.
REQ-023 SHALL ignore abort outside RUN.
REQ-024 SHALL, in exhaustive mode, drive {a_out,b_out,cin_out} from a (2*NBITS+1)-bit counter that starts at 0, increments per transfer, and wraps modulo 2^(2*NBITS+1) without stopping the run.
REQ-025 SHALL keep valid low in IDLE and DONE.

Reset
REQ-026 SHALL, on rst_n=0 at any time including mid-run, immediately force state IDLE, valid=0, busy=0, done=0, vec_count=0, a_out=0, b_out=0, cin_out=0, pattern counter=0 and LFSR=1.
REQ-027 SHALL present no vector after reset deassertion until start is sampled high.

Configuration
REQ-028 SHALL compile in random mode when macro OPERAND_GEN_LFSR_EN is defined, adding input mode (1 bit, 1=random) and input seed (32 bits) sampled at start.
REQ-029 SHALL, in random mode, use a 32-bit Galois LFSR with taps 0x80200003, loaded with seed at start or 1 when seed=0, and stepped once per transfer.
REQ-030 SHALL, in random mode, map a_out=lfsr[NBITS-1:0], b_out=lfsr[2*NBITS-1:NBITS] and cin_out=lfsr[31].
REQ-031 SHALL, without OPERAND_GEN_LFSR_EN, omit the mode and seed ports and the LFSR, and run exhaustive mode only.

Structure
REQ-032 SHALL take the state encoding and LFSR tap constant from shared package operand_gen_pkg.
REQ-033 SHALL implement the LFSR as sub-module lfsr32 (ports clk, rst_n, load, seed, step, q), instantiated only under OPERAND_GEN_LFSR_EN.

Verification
REQ-034 SHALL cover: NBITS=4, NUM_VECTORS=3, ready=1, start -> vectors (a,b,cin) = (0,0,0), (0,0,1), (0,1,0), then done=1 and vec_count=3.
REQ-035 SHALL cover: ready=0 for 5 cycles on the 2nd vector -> vector and valid held unchanged, vec_count stays 1.
REQ-036 SHALL cover: NBITS=1, NUM_VECTORS=10 -> counter wraps after vector 8 to (0,0,0), and done follows the 10th transfer.
REQ-037 SHALL cover: abort after 2 transfers -> IDLE, valid=0, vec_count=2; a following start gives vec_count=0 and first vector (0,0,0).
REQ-038 SHALL cover: with OPERAND_GEN_LFSR_EN, mode=1, seed=0, NBITS=4 -> first vector a=1, b=0, cin=0.
REQ-039 SHALL cover: rst_n low mid-run -> all outputs 0 the same cycle, state IDLE; restart from DONE via start yields a fresh run.
